wb_mem_model: RTL

//  Parametrised Wishbone B3 slave memory model; successor to the fixed 64-bit harness.

---
 rtl/wb_mem_pkg.sv | 26 ++
 rtl/wb_mem_array.sv | 32 +++
 rtl/wb_mem_model.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_mem_pkg.sv
// Shared constants, types and helpers for the Wishbone B3 slave memory model.
package wb_mem_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CTI_W  = 3;
  localparam int unsigned BTE_W  = 2;
  localparam int unsigned WAIT_W = 4;

  localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
  localparam logic [CTI_W-1:0] CTI_END     = 3'b111;
  localparam logic [BTE_W-1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    RECOVER
  } state_t;

  // Cycle types this slave does not implement are answered with an error.
  function automatic logic cti_reserved(input logic [CTI_W-1:0] cti);
    return !((cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_END));
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Word-organised storage: asynchronous read, byte-enabled synchronous write.
// Contents have no reset and start undefined until written over the bus.
module wb_mem_array #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned ADDR_BITS  = 24
) (
  input  logic                    clk,
  input  logic [ADDR_BITS-1:0]    addr,
  output logic [8*DATA_BYTES-1:0] rdata,
  input  logic                    we,
  input  logic [DATA_BYTES-1:0]   sel,
  input  logic [8*DATA_BYTES-1:0] wdata
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;
  localparam int unsigned DEPTH  = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (sel[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/wb_mem_model.sv
// Wishbone B3 slave memory model: configurable width, depth and wait states,
// registered-feedback linear incrementing bursts and an error response.
module wb_mem_model
  import wb_mem_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = 8,
  parameter int unsigned ADDR_BITS   = 24,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    sys_clock_i,
  input  logic                    sys_reset_i,
  input  logic [ADDR_W-1:0]       wbs_addr_i,
  input  logic [8*DATA_BYTES-1:0] wbs_data_i,
  output logic [8*DATA_BYTES-1:0] wbs_data_o,
  input  logic [DATA_BYTES-1:0]   wbs_sel_i,
  input  logic                    wbs_we_i,
  input  logic                    wbs_cycle_i,
  input  logic                    wbs_strobe_i,
  input  logic [CTI_W-1:0]        wbs_cti_i,
  input  logic [BTE_W-1:0]        wbs_bte_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o
);

  localparam int unsigned DATA_W = 8 * DATA_BYTES;
  localparam int unsigned LSB    = $clog2(DATA_BYTES);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 oor_q, oor_d;
  logic                 we_q, we_d;
  logic                 ack_d, err_d;
  logic [DATA_W-1:0]    data_d;
  logic [DATA_W-1:0]    rdata;
  logic [ADDR_W-1:0]    word_addr;
  logic                 req;
  logic                 beat_err;
  logic                 mem_we_c;

  assign req       = wbs_cycle_i & wbs_strobe_i;
  assign word_addr = wbs_addr_i >> LSB;
  assign beat_err  = oor_q | cti_reserved(wbs_cti_i) |
                     ((wbs_cti_i == CTI_INCR) && (wbs_bte_i != BTE_LINEAR));

  wb_mem_array #(
    .DATA_BYTES (DATA_BYTES),
    .ADDR_BITS  (ADDR_BITS)
  ) u_array (
    .clk   (sys_clock_i),
    .addr  (addr_q),
    .rdata (rdata),
    .we    (mem_we_c & sys_reset_i),
    .sel   (wbs_sel_i),
    .wdata (wbs_data_i)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    oor_d    = oor_q;
    we_d     = we_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    data_d   = '0;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = word_addr[ADDR_BITS-1:0];
          oor_d   = (word_addr >> ADDR_BITS) != '0;
          we_d    = wbs_we_i;
          cnt_d   = WAIT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (!req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == WAIT_W'(1)) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (!req) begin
          state_d = IDLE;
        end else if (beat_err) begin
          err_d   = 1'b1;
          state_d = RECOVER;
        end else begin
          ack_d    = 1'b1;
          mem_we_c = we_q;
          data_d   = we_q ? '0 : rdata;
          // Only an incrementing beat keeps the burst going; the index wraps naturally.
          if (wbs_cti_i == CTI_INCR) begin
            addr_d = addr_q + ADDR_BITS'(1);
            oor_d  = 1'b0;
          end else begin
            state_d = RECOVER;
          end
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      we_q       <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_data_o <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      we_q       <= we_d;
      wbs_ack_o  <= ack_d;
      wbs_err_o  <= err_d;
      wbs_data_o <= data_d;
    end
  end

endmodule
